// File: rtl/rtc_time_keeper.sv
// 24-hour real-time clock with programmable tick divider, validated load, sticky alarm and carry pulses.
// Optional macro RTC_BCD_OUT_EN: s_out/m_out/h_out are packed BCD; otherwise they are plain binary.
module rtc_time_keeper #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned DIV_W    = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       set_vld,
    input  logic [7:0] set_h,
    input  logic [7:0] set_m,
    input  logic [7:0] set_s,
    output logic       set_err,
    input  logic       alm_en,
    input  logic [7:0] alm_h,
    input  logic [7:0] alm_m,
    input  logic [7:0] alm_s,
    input  logic       alm_clr,
    output logic       alm_flag,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       day_wrap,
    output logic [7:0] s_out,
    output logic [7:0] m_out,
    output logic [7:0] h_out
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       sec_q, min_q, hr_q;
    logic [7:0]       sec_d, min_d, hr_d;
    logic             set_ok, due, adv;
    logic             sec_wrap, min_wrap, hr_wrap;
    logic             alm_hit;

    always_comb begin
        set_ok   = set_vld && (set_h <= 8'd23) && (set_m <= 8'd59) && (set_s <= 8'd59);
        due      = run && (div_cnt == DIV_LAST);
        // A valid load on the wrap cycle swallows that second's advance.
        adv      = due && !set_ok;
        sec_wrap = (sec_q == 8'd59);
        min_wrap = sec_wrap && (min_q == 8'd59);
        hr_wrap  = min_wrap && (hr_q == 8'd23);
        sec_d    = sec_q;
        min_d    = min_q;
        hr_d     = hr_q;
        if (set_ok) begin
            sec_d = set_s;
            min_d = set_m;
            hr_d  = set_h;
        end else if (adv) begin
            sec_d = sec_wrap ? '0 : sec_q + 8'd1;
            if (sec_wrap) min_d = (min_q == 8'd59) ? '0 : min_q + 8'd1;
            if (min_wrap) hr_d = hr_wrap ? '0 : hr_q + 8'd1;
        end
        // Time is always in range, so out-of-range alarm fields can never compare equal.
        alm_hit  = adv && alm_en && (hr_d == alm_h) && (min_d == alm_m) && (sec_d == alm_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            hr_q     <= '0;
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            day_wrap <= 1'b0;
            set_err  <= 1'b0;
            alm_flag <= 1'b0;
        end else begin
            sec_q    <= sec_d;
            min_q    <= min_d;
            hr_q     <= hr_d;
            sec_tick <= adv;
            min_tick <= adv && sec_wrap;
            day_wrap <= adv && hr_wrap;
            set_err  <= set_vld && !set_ok;
            if (set_ok)
                div_cnt <= '0;
            else if (run)
                div_cnt <= due ? '0 : div_cnt + DIV_W'(1);
            if (alm_hit)
                alm_flag <= 1'b1;
            else if (alm_clr)
                alm_flag <= 1'b0;
        end
    end

`ifdef RTC_BCD_OUT_EN
    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        return {4'(v / 8'd10), 4'(v % 8'd10)};
    endfunction

    // Converted from the next-state values so BCD outputs share the binary latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_out <= '0;
            m_out <= '0;
            h_out <= '0;
        end else begin
            s_out <= to_bcd(sec_d);
            m_out <= to_bcd(min_d);
            h_out <= to_bcd(hr_d);
        end
    end
`else
    assign s_out = sec_q;
    assign m_out = min_q;
    assign h_out = hr_q;
`endif

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Self-checking bench for rtc_time_keeper (TICK_DIV=4): vector table, corner sequences, random vs seconds-of-day model.
module tb_rtc_time_keeper;

    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0, set_vld = 1'b0, alm_en = 1'b0, alm_clr = 1'b0;
    logic [7:0] set_h = '0, set_m = '0, set_s = '0;
    logic [7:0] alm_h = '0, alm_m = '0, alm_s = '0;
    logic       set_err, alm_flag, sec_tick, min_tick, day_wrap;
    logic [7:0] s_out, m_out, h_out;

    int checks = 0;
    int failures = 0;

    // Reference model: time as seconds since midnight.
    int m_tod = 0, m_div = 0;
    bit m_flag = 0, e_sec = 0, e_min = 0, e_day = 0, e_err = 0;

    rtc_time_keeper #(.TICK_DIV(TDIV), .DIV_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .set_vld(set_vld),
        .set_h(set_h), .set_m(set_m), .set_s(set_s), .set_err(set_err),
        .alm_en(alm_en), .alm_h(alm_h), .alm_m(alm_m), .alm_s(alm_s),
        .alm_clr(alm_clr), .alm_flag(alm_flag), .sec_tick(sec_tick),
        .min_tick(min_tick), .day_wrap(day_wrap),
        .s_out(s_out), .m_out(m_out), .h_out(h_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] enc(input int v);
`ifdef RTC_BCD_OUT_EN
        return 8'((v / 10) * 16 + (v % 10));
`else
        return 8'(v);
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tod = 0; m_div = 0; m_flag = 0;
        e_sec = 0; e_min = 0; e_day = 0; e_err = 0;
    endtask

    task automatic cmp_model();
        chk("h_out", h_out, enc(m_tod / 3600));
        chk("m_out", m_out, enc((m_tod / 60) % 60));
        chk("s_out", s_out, enc(m_tod % 60));
        chk("sec_tick", sec_tick, e_sec);
        chk("min_tick", min_tick, e_min);
        chk("day_wrap", day_wrap, e_day);
        chk("set_err", set_err, e_err);
        chk("alm_flag", alm_flag, m_flag);
    endtask

    // Advance the model with the currently driven inputs, clock once, compare.
    task automatic cycle();
        bit ok, hit;
        ok = set_vld && set_h <= 23 && set_m <= 59 && set_s <= 59;
        e_sec = 0; e_min = 0; e_day = 0; hit = 0;
        e_err = set_vld && !ok;
        if (ok) begin
            m_tod = int'(set_h) * 3600 + int'(set_m) * 60 + int'(set_s);
            m_div = 0;
        end else if (run) begin
            if (m_div == TDIV - 1) begin
                m_div = 0;
                m_tod = (m_tod + 1) % 86400;
                e_sec = 1;
                e_min = (m_tod % 60 == 0);
                e_day = (m_tod == 0);
                if (alm_en && alm_h <= 23 && alm_m <= 59 && alm_s <= 59 &&
                    m_tod == int'(alm_h) * 3600 + int'(alm_m) * 60 + int'(alm_s))
                    hit = 1;
            end else begin
                m_div++;
            end
        end
        if (hit) m_flag = 1;
        else if (alm_clr) m_flag = 0;
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic load(input int h, input int m, input int s);
        set_vld = 1'b1; set_h = 8'(h); set_m = 8'(m); set_s = 8'(s);
    endtask

    typedef struct {
        bit run; bit sv; int sh; int sm; int ss;
        int eh; int em; int es; bit esec; bit emin; bit eday; bit eerr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int ticks, first_t, last_t, n;
        bit found;

        tbl[0]  = '{0, 1, 23, 59, 58, 23, 59, 58, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0,    23, 59, 58, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0,    23, 59, 58, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0,    23, 59, 58, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0,    23, 59, 59, 1, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0,    23, 59, 59, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0,    23, 59, 59, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 0,    23, 59, 59, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 0,    0, 0, 0,    1, 1, 1, 0};
        tbl[9]  = '{0, 1, 5, 60, 7,   0, 0, 0,    0, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0};
        tbl[11] = '{0, 1, 23, 0, 0,   23, 0, 0,   0, 0, 0, 0};

        // Reset state
        #3;
        model_reset();
        cmp_model();
        #9 rst_n = 1'b1;

        // Free run from reset: three ticks, four cycles apart
        run = 1'b1; ticks = 0; first_t = -1; last_t = -1;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (sec_tick) begin
                if (ticks > 0) chk("tick_spacing", i - last_t, 4);
                if (first_t < 0) first_t = i;
                last_t = i;
                ticks++;
            end
        end
        chk("tick_count", ticks, 3);
        chk("first_tick", first_t, 4);
        chk("s_after_12", s_out, enc(3));

        // Vector table: day wrap and load validation
        for (int i = 0; i < 12; i++) begin
            run = tbl[i].run; set_vld = tbl[i].sv;
            set_h = 8'(tbl[i].sh); set_m = 8'(tbl[i].sm); set_s = 8'(tbl[i].ss);
            cycle();
            chk("tbl_h", h_out, enc(tbl[i].eh));
            chk("tbl_m", m_out, enc(tbl[i].em));
            chk("tbl_s", s_out, enc(tbl[i].es));
            chk("tbl_sec", sec_tick, tbl[i].esec);
            chk("tbl_min", min_tick, tbl[i].emin);
            chk("tbl_day", day_wrap, tbl[i].eday);
            chk("tbl_err", set_err, tbl[i].eerr);
        end
        set_vld = 1'b0;

        // Alarm at 00:00:02
        alm_h = 8'd0; alm_m = 8'd0; alm_s = 8'd2; alm_en = 1'b1; run = 1'b1;
        load(0, 0, 0); cycle(); set_vld = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (alm_flag) begin
                found = 1;
                chk("alm_rise_s", s_out, enc(2));
                chk("alm_rise_tick", sec_tick, 1);
            end
        end
        chk("alm_rise_seen", found, 1);
        repeat (3) cycle();
        chk("alm_sticky", alm_flag, 1);
        alm_clr = 1'b1; cycle(); alm_clr = 1'b0;
        chk("alm_cleared", alm_flag, 0);
        load(0, 0, 2); cycle(); set_vld = 1'b0;
        chk("alm_load_no_trig", alm_flag, 0);

        // Clear and match on the same edge: set wins
        load(0, 0, 1); cycle(); set_vld = 1'b0;
        alm_clr = 1'b1; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (sec_tick) begin
                found = 1;
                chk("alm_set_wins", alm_flag, 1);
            end
        end
        chk("alm_set_wins_seen", found, 1);
        cycle();
        chk("alm_clr_after", alm_flag, 0);
        alm_clr = 1'b0;

        // Out-of-range alarm field never matches (00:00:62 is not 00:01:02)
        alm_s = 8'd62;
        load(0, 1, 1); cycle(); set_vld = 1'b0;
        repeat (TDIV) cycle();
        chk("alm_oor_s", s_out, enc(2));
        chk("alm_oor_flag", alm_flag, 0);
        alm_en = 1'b0;

        // Load coincident with the divider wrap
        load(0, 0, 5); cycle(); set_vld = 1'b0;
        repeat (TDIV - 1) cycle();
        load(1, 2, 3); cycle(); set_vld = 1'b0;
        chk("coinc_h", h_out, enc(1));
        chk("coinc_m", m_out, enc(2));
        chk("coinc_s", s_out, enc(3));
        chk("coinc_no_tick", sec_tick, 0);
        n = 0; found = 0;
        for (int i = 1; i <= 10 && !found; i++) begin
            cycle();
            if (sec_tick) begin found = 1; n = i; end
        end
        chk("coinc_next_tick", n, 4);
        chk("coinc_next_s", s_out, enc(4));

        // Pause mid-count, then asynchronous reset mid-second
        cycle(); cycle();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("pause_s", s_out, enc(4));
        end
        run = 1'b1; cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        cmp_model();
        #1 rst_n = 1'b1;

        // Packed-BCD (or binary) presentation
        load(12, 34, 56); cycle(); set_vld = 1'b0;
`ifdef RTC_BCD_OUT_EN
        chk("bcd_h", h_out, 8'h12);
        chk("bcd_m", m_out, 8'h34);
        chk("bcd_s", s_out, 8'h56);
`else
        chk("bin_h", h_out, 8'd12);
        chk("bin_m", m_out, 8'd34);
        chk("bin_s", s_out, 8'd56);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            run = ($urandom % 8) != 0;
            set_vld = ($urandom % 16) == 0;
            if (set_vld) begin
                if ($urandom % 3 == 0) begin
                    set_h = 8'($urandom_range(0, 26));
                    set_m = 8'($urandom_range(0, 63));
                    set_s = 8'($urandom_range(0, 63));
                end else begin
                    set_h = 8'($urandom_range(22, 23));
                    set_m = 8'($urandom_range(58, 59));
                    set_s = 8'($urandom_range(50, 59));
                end
            end
            if ($urandom % 24 == 0) begin
                n = (m_tod + int'($urandom_range(1, 3))) % 86400;
                alm_h = 8'(n / 3600); alm_m = 8'((n / 60) % 60); alm_s = 8'(n % 60);
                if ($urandom % 4 == 0) alm_s = 8'($urandom_range(60, 255));
            end
            alm_en = ($urandom % 4) != 0;
            alm_clr = ($urandom % 12) == 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
